// File: rtl/oram_access_arbiter_pkg.sv
// Shared types and widths for the ORAM access arbiter and its round-robin picker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package oram_access_arbiter_pkg;

  // oram_module geometry: d = block-number width, a = data width in bytes
  localparam int ORAM_D  = 4;
  localparam int ORAM_A  = 2;
  localparam int ORAM_DW = 8 * ORAM_A;

  localparam int ORAM_ARB_NREQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    CLEAR = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic                rw;
    logic [ORAM_D-1:0]   block;
    logic [ORAM_DW-1:0]  wdata;
  } oram_req_t;

  // Successor of a client index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/oram_access_arbiter_rr.sv
// Round-robin picker: first asserted valid at or after rr_ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module oram_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  // Scan offsets from farthest to nearest so the candidate closest to rr_ptr wins
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/oram_access_arbiter.sv
// Shares one oram_module among N_REQ clients: round-robin grant, one access in flight.
// Latency: accept -> resp_valid is 3 cycles + oram latency; grants spaced >= 4+CLR_CYC cycles.
// Backpressure: a client waits (req_valid held) until its one-cycle req_ready strobe; no resp stall.
module oram_access_arbiter
  import oram_access_arbiter_pkg::*;
#(
  parameter  int N_REQ   = ORAM_ARB_NREQ_DEF,
  parameter  int CLR_CYC = 1,
  parameter  int TMO_CYC = 1024,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int D       = ORAM_D,
  localparam int DW      = ORAM_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_rw,
  input  logic [N_REQ*D-1:0]  req_block,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_ready,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_id,
  output logic [DW-1:0]       resp_rdata,
  output logic                resp_err,
  output logic [D-1:0]        oram_block_num,
  output logic [DW-1:0]       oram_write_val,
  output logic                oram_rw,
  output logic                oram_input_ready,
  output logic                oram_rst,
  input  logic [DW-1:0]       oram_read_val,
  input  logic                oram_output_ready
);

  localparam int CLR_W = $clog2(CLR_CYC + 1);
  // A disabled watchdog still needs a legal one-bit counter
  localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  arb_state_t       state_q,   state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [ID_W-1:0]  id_q,      id_d;
  oram_req_t        req_q,     req_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic             err_q,     err_d;
  logic [TMO_W-1:0] wdt_q,     wdt_d;

  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic [TMO_W-1:0] wdt_inc;
  logic             wdt_hit;
  logic             busy;

  oram_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid       (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign wdt_inc = wdt_q + 1'b1;
  assign wdt_hit = (TMO_CYC != 0) && (wdt_inc == TMO_W'(TMO_CYC));

  // Access sequencer: grant/latch, drive oram, wait for done or watchdog, respond, soft-clear
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wdt_d     = wdt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d        = grant_id;
          req_d.rw    = req_rw[grant_id];
          req_d.block = req_block[int'(grant_id)*D +: D];
          req_d.wdata = req_wdata[int'(grant_id)*DW +: DW];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Watchdog restarts here so WAIT always begins at zero
        wdt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (oram_output_ready) begin
          rdata_d = oram_read_val;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdt_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdt_d = wdt_inc;
        end
      end
      RESP: begin
        rr_ptr_d  = ID_W'(rr_next(int'(id_q), N_REQ));
        clr_cnt_d = CLR_W'(CLR_CYC);
        state_d   = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_q <= CLR_W'(1)) state_d = IDLE;
        else                        clr_cnt_d = clr_cnt_q - 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Output decode straight from state so an async reset forces oram_rst high at once
  always_comb begin
    busy             = (state_q == ISSUE) || (state_q == WAIT);
    oram_input_ready = busy;
    oram_rst         = (state_q == CLEAR);
    oram_block_num   = busy ? req_q.block : '0;
    oram_write_val   = busy ? req_q.wdata : '0;
    oram_rw          = busy & req_q.rw;
    req_ready        = '0;
    if ((state_q == IDLE) && grant_valid) req_ready[grant_id] = 1'b1;
    resp_valid       = (state_q == RESP);
    resp_id          = resp_valid ? id_q : '0;
    resp_rdata       = (resp_valid && !req_q.rw) ? rdata_q : '0;
    resp_err         = resp_valid & err_q;
  end

  // State registers; reset abandons any in-flight access and re-enters the soft-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= CLR_W'(CLR_CYC);
      rr_ptr_q  <= '0;
      id_q      <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wdt_q     <= wdt_d;
    end
  end

endmodule

// File: tb/tb_oram_access_arbiter.sv
// Self-checking bench for oram_access_arbiter with a behavioural oram responder and scoreboard.
// Latency: n/a.
// Backpressure: clients hold requests until their req_ready strobe.
module tb_oram_access_arbiter;
  import oram_access_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int CLR = 2;
  localparam int TMO = 16;
  localparam int D   = ORAM_D;
  localparam int DW  = ORAM_DW;
  localparam int IW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_rw = '0;
  logic [N*D-1:0]  req_block = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [D-1:0]    oram_block_num;
  logic [DW-1:0]   oram_write_val;
  logic            oram_rw;
  logic            oram_input_ready;
  logic            oram_rst;
  logic [DW-1:0]   oram_read_val = '0;
  logic            oram_output_ready = 1'b0;

  oram_access_arbiter #(.N_REQ(N), .CLR_CYC(CLR), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_block(req_block), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .oram_block_num(oram_block_num), .oram_write_val(oram_write_val), .oram_rw(oram_rw),
    .oram_input_ready(oram_input_ready), .oram_rst(oram_rst),
    .oram_read_val(oram_read_val), .oram_output_ready(oram_output_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // oram behaviour knobs
  int  lat   = 1;
  bit  hang  = 1'b0;
  bit  noise = 1'b0;
  logic [DW-1:0] omem [16] = '{default: '0};
  int  ocnt  = 0;
  bit  fired = 1'b0;

  // Behavioural oram_module: answers lat cycles after input_ready rises; noise drives a
  // spurious output_ready whenever the arbiter must ignore it (idle/clear and the issue cycle)
  always @(negedge clk) begin
    if (oram_rst || !oram_input_ready) begin
      ocnt = 0; fired = 1'b0; oram_output_ready = noise;
    end else if (fired) begin
      oram_output_ready = 1'b0;
    end else if (!hang && ocnt >= lat) begin
      fired = 1'b1; oram_output_ready = 1'b1;
      if (oram_rw) omem[oram_block_num] = oram_write_val;
      else         oram_read_val = omem[oram_block_num];
    end else begin
      oram_output_ready = (ocnt == 0) ? noise : 1'b0;
      ocnt++;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  int  m_ptr = 0;
  bit  m_busy = 1'b0;
  int  m_id = 0, m_blk = 0, m_gcyc = 0, m_lat = 0;
  bit  m_rw = 1'b0, m_hang = 1'b0;
  logic [DW-1:0] m_wd = '0;
  int  cyc = 0, idle_from = 0, rst_run = 0;
  bit  prev_resp = 1'b0, resp_now = 1'b0, rnd_mode = 1'b0;
  int  gnt_log[$];
  int  last_resp_id = -1;
  logic [DW-1:0] last_rdata = '0;
  bit  last_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic post(input int i, input bit rw, input int blk, input logic [DW-1:0] wd);
    req_valid[i] = 1'b1;
    req_rw[i] = rw;
    req_block[i*D +: D] = D'(blk);
    req_wdata[i*DW +: DW] = wd;
  endtask

  // One clock: check everything at the falling edge, then act as the clients after the rise
  task automatic tick();
    logic [N-1:0] drop, exp_mask;
    int e;
    drop = '0;
    @(negedge clk);
    cyc++;
    resp_now = resp_valid;
    if (rst) begin
      rst_run = 0; idle_from = cyc + 1 + CLR;
    end else if (oram_rst) begin
      rst_run++;
    end else if (rst_run != 0) begin
      chk("clear_len", rst_run, CLR); rst_run = 0;
    end
    if (prev_resp) chk("rst_after_resp", oram_rst, 1);
    prev_resp = 1'b0;
    if (!rst && !m_busy && req_valid != '0 && cyc >= idle_from)
      chk("idle_grant", req_ready != '0, 1);
    if (req_ready != '0) begin
      e = pick(req_valid, m_ptr);
      exp_mask = '0;
      if (e >= 0) exp_mask[e] = 1'b1;
      chk("grant_id", req_ready, exp_mask);
      chk("grant_when_idle", !m_busy && cyc >= idle_from, 1);
      if (e >= 0) begin
        m_busy = 1'b1; m_id = e; m_rw = req_rw[e];
        m_blk = int'(req_block[e*D +: D]); m_wd = req_wdata[e*DW +: DW];
        m_gcyc = cyc; gnt_log.push_back(e); drop[e] = 1'b1;
        if (rnd_mode) begin
          lat = int'($urandom_range(1, 4));
          hang = ($urandom_range(0, 7) == 0);
          noise = 1'($urandom_range(0, 1));
        end
        m_hang = hang; m_lat = lat;
      end
    end
    if (m_busy && cyc > m_gcyc && !resp_valid) begin
      chk("in_rdy", oram_input_ready, 1);
      chk("o_blk", oram_block_num, m_blk);
      chk("o_rw", oram_rw, m_rw);
      chk("o_wval", oram_write_val, m_wd);
      chk("o_rst", oram_rst, 0);
      chk("wait_bound", (cyc - m_gcyc) < 3 + TMO, 1);
    end
    if (resp_valid) begin
      chk("resp_busy", m_busy, 1);
      chk("resp_id", resp_id, m_id);
      chk("resp_err", resp_err, m_hang);
      chk("resp_rdata", resp_rdata, (m_hang || m_rw) ? DW'(0) : ref_mem[m_blk]);
      chk("resp_lat", cyc - m_gcyc, m_hang ? 2 + TMO : 2 + m_lat);
      chk("resp_inrdy", oram_input_ready, 0);
      if (!m_hang && m_rw) ref_mem[m_blk] = m_wd;
      m_ptr = (m_id + 1) % N; m_busy = 1'b0; idle_from = cyc + 1 + CLR; prev_resp = 1'b1;
      last_resp_id = int'(resp_id); last_rdata = resp_rdata; last_err = resp_err;
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~drop;
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          post(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DW'($urandom));
        else if (req_valid[i] && $urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || m_busy) && n < budget) begin tick(); n++; end
    chk("quiet_bound", (req_valid == '0) && !m_busy, 1);
    repeat (CLR + 1) tick();
  endtask

  initial begin
    int t3_exp[5] = '{0, 1, 2, 3, 0};
    int n, c1;
    bit re;

    // Reset state
    tick();
    chk("rst_oram_rst", oram_rst, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_in_rdy", oram_input_ready, 0);
    chk("rst_blk", oram_block_num, 0);
    chk("rst_wval", oram_write_val, 0);
    tick();
    rst = 1'b0;

    // 1: single write
    post(0, 1'b1, 1, 16'd2);
    run_quiet(50);
    chk("t1_id", last_resp_id, 0);
    chk("t1_rdata", last_rdata, 0);
    chk("t1_err", last_err, 0);

    // 2: write then read back
    post(1, 1'b1, 3, 16'd10);
    run_quiet(50);
    post(1, 1'b0, 3, 16'd0);
    run_quiet(50);
    chk("t2_id", last_resp_id, 1);
    chk("t2_rdata", last_rdata, 10);

    // 3: contention from reset, client 0 re-raised after its response
    rst = 1'b1; m_busy = 1'b0; m_ptr = 0;
    tick(); tick();
    rst = 1'b0;
    gnt_log.delete();
    for (int i = 0; i < N; i++) post(i, 1'b0, i, 16'd0);
    n = 0; re = 1'b0;
    while (n < 200 && (gnt_log.size() < 5 || m_busy || req_valid != '0)) begin
      tick(); n++;
      if (!re && resp_now && last_resp_id == 0) begin post(0, 1'b1, 9, 16'h55); re = 1'b1; end
    end
    repeat (CLR + 1) tick();
    chk("t3_count", gnt_log.size(), 5);
    for (int k = 0; k < gnt_log.size() && k < 5; k++) chk("t3_order", gnt_log[k], t3_exp[k]);

    // 4: watchdog abort, then a normal access
    hang = 1'b1;
    post(2, 1'b0, 3, 16'd0);
    run_quiet(100);
    chk("t4_err", last_err, 1);
    chk("t4_rdata", last_rdata, 0);
    chk("t4_id", last_resp_id, 2);
    hang = 1'b0;
    post(3, 1'b0, 3, 16'd0);
    run_quiet(50);
    chk("t4_next_err", last_err, 0);
    chk("t4_next_rdata", last_rdata, 10);

    // Spurious output_ready while idle and at issue must be ignored
    noise = 1'b1;
    repeat (6) tick();
    post(0, 1'b1, 4, 16'hBEEF);
    run_quiet(50);
    noise = 1'b0;
    post(2, 1'b0, 4, 16'd0);
    run_quiet(50);
    chk("noise_rdata", last_rdata, 16'hBEEF);

    // 5: reset in the middle of WAIT
    lat = 8;
    post(2, 1'b1, 7, 16'd99);
    n = 0;
    while (n < 40 && !(m_busy && oram_input_ready && cyc >= m_gcyc + 3)) begin tick(); n++; end
    chk("t5_in_wait", m_busy && oram_input_ready, 1);
    rst = 1'b1;
    #1;
    chk("t5_oram_rst", oram_rst, 1);
    chk("t5_in_rdy", oram_input_ready, 0);
    chk("t5_blk", oram_block_num, 0);
    chk("t5_rw", oram_rw, 0);
    chk("t5_wval", oram_write_val, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_req_ready", req_ready, 0);
    m_busy = 1'b0; m_ptr = 0;
    tick(); tick();
    rst = 1'b0;
    lat = 1;
    gnt_log.delete();
    post(3, 1'b0, 7, 16'd0);
    post(1, 1'b0, 7, 16'd0);
    run_quiet(60);
    if (gnt_log.size() >= 1) chk("t5_ptr_zero", gnt_log[0], 1);
    chk("t5_abandoned_write", last_rdata, 0);

    // 6: client 1 withdraws before being granted
    gnt_log.delete();
    lat = 3;
    post(0, 1'b0, 1, 16'd0);
    n = 0;
    while (n < 20 && gnt_log.size() == 0) begin tick(); n++; end
    post(1, 1'b1, 5, 16'h77);
    tick(); tick();
    req_valid[1] = 1'b0;
    post(2, 1'b0, 1, 16'd0);
    run_quiet(60);
    chk("t6_grants", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) chk("t6_skip1", gnt_log[1], 2);
    c1 = 0;
    foreach (gnt_log[k]) if (gnt_log[k] == 1) c1++;
    chk("t6_no_ready1", c1, 0);

    // Randomised traffic against the scoreboard
    rnd_mode = 1'b1;
    repeat (3000) tick();
    rnd_mode = 1'b0;
    run_quiet(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
